// File: rtl/sram_sp_masked_init.sv
// sram_sp_masked_init
//   Single-port synchronous SRAM with per-segment write mask, optional output
//   register and a built-in zero-initialisation engine. The array is cleared
//   one entry per cycle after reset release or after an accepted init_req.
//   Read data holds its last value between reads.
//
// Ports
//   RW0_clk     clock
//   RW0_rst_n   asynchronous active-low reset
//   RW0_addr    entry address (ADDR_W bits)
//   RW0_en      access enable
//   RW0_wmode   1 = write, 0 = read
//   RW0_wmask   per-segment write enable (MASK_W bits)
//   RW0_wdata   write data (WIDTH bits)
//   RW0_rdata   read data, held between reads
//   RW0_rvalid  one-cycle pulse when RW0_rdata carries a new read result
//   RW0_ready   1 = accesses accepted, 0 = initialisation in progress
//   init_req    single-cycle request to re-run zero initialisation
module sram_sp_masked_init #(
  parameter  int DEPTH     = 4,
  parameter  int WIDTH     = 261,
  parameter  int MASK_GRAN = 261,
  parameter  int OUT_REG   = 0,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int MASK_W    = (WIDTH + MASK_GRAN - 1) / MASK_GRAN
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic [WIDTH-1:0]  RW0_wdata,
  output logic [WIDTH-1:0]  RW0_rdata,
  output logic              RW0_rvalid,
  output logic              RW0_ready,
  input  logic              init_req
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_cnt;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [WIDTH-1:0]   r_rd_data;
  logic               r_rd_valid;

  logic               w_ready;
  logic               w_in_range;
  logic               w_wr;
  logic               w_rd;
  logic               w_init_we;
  logic [WIDTH-1:0]   w_bitmask;

  assign w_ready = (r_state == ST_READY);

  // Only a non-power-of-two depth can see addresses past the last entry.
  if ((2 ** ADDR_W) == DEPTH) begin : g_pow2
    assign w_in_range = 1'b1;
  end else begin : g_npow2
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    assign w_in_range = ({1'b0, RW0_addr} < DEPTH_L);
  end

  assign w_wr      = RW0_en &  RW0_wmode & w_ready & w_in_range;
  assign w_rd      = RW0_en & ~RW0_wmode & w_ready;
  // Init writes are held off while reset is asserted so reset alone never
  // modifies the array.
  assign w_init_we = (r_state == ST_INIT) & RW0_rst_n;

  // Expand the segment mask to a bit mask; the last segment may be partial.
  for (genvar s = 0; s < MASK_W; s++) begin : g_seg
    localparam int LO = s * MASK_GRAN;
    localparam int HI = ((s + 1) * MASK_GRAN < WIDTH) ? (s + 1) * MASK_GRAN : WIDTH;
    assign w_bitmask[HI-1:LO] = {(HI - LO){RW0_wmask[s]}};
  end

  // Init state machine
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (init_req) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Storage array; no reset on contents
  always_ff @(posedge RW0_clk) begin
    if (w_init_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      r_mem[RW0_addr] <= (r_mem[RW0_addr] & ~w_bitmask) | (RW0_wdata & w_bitmask);
    end
  end

  // First read stage: data only updates on a read, otherwise it holds.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_in_range ? r_mem[RW0_addr] : '0;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else begin
        r_out_valid <= r_rd_valid;
        if (r_rd_valid) begin
          r_out_data <= r_rd_data;
        end
      end
    end

    assign RW0_rdata  = r_out_data;
    assign RW0_rvalid = r_out_valid;
  end else begin : g_no_out_reg
    assign RW0_rdata  = r_rd_data;
    assign RW0_rvalid = r_rd_valid;
  end

  assign RW0_ready = w_ready;

endmodule

// File: tb/tb_sram_sp_masked_init.sv
// Two instances share one stimulus stream:
//   A: DEPTH=5, MASK_GRAN=128, OUT_REG=1 (non-power-of-two depth, latency 2)
//   B: DEPTH=4, MASK_GRAN=100, OUT_REG=0 (latency 1, sees addr[1:0])
module tb_sram_sp_masked_init;

  localparam int W = 261;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en, wmode, init_req;
  logic [2:0]   addr, wmask;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata_a, rdata_b;
  logic         rvalid_a, rvalid_b, ready_a, ready_b;

  sram_sp_masked_init #(.DEPTH(5), .WIDTH(W), .MASK_GRAN(128), .OUT_REG(1)) u_dut_a (
    .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en),
    .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
    .RW0_rdata(rdata_a), .RW0_rvalid(rvalid_a), .RW0_ready(ready_a),
    .init_req(init_req)
  );

  sram_sp_masked_init #(.DEPTH(4), .WIDTH(W), .MASK_GRAN(100), .OUT_REG(0)) u_dut_b (
    .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr[1:0]), .RW0_en(en),
    .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
    .RW0_rdata(rdata_b), .RW0_rvalid(rvalid_b), .RW0_ready(ready_b),
    .init_req(init_req)
  );

  // ---------------- reference model ----------------
  int D [2] = '{5, 4};
  int L [2] = '{2, 1};
  int G [2] = '{128, 100};

  typedef struct {
    int           k;
    int           due;
    logic [W-1:0] d;
  } res_t;

  logic [W-1:0] mm [2][8];
  int           init_left [2];
  logic         exp_v [2];
  logic [W-1:0] exp_d [2];
  res_t         q [$];
  int           cyc_n    = 0;
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge of the behavioural model for instance k.
  function automatic void model_step(input int k);
    int   a;
    int   idx;
    res_t r;
    if (!rst_n) begin
      init_left[k] = D[k];
      exp_v[k]     = 1'b0;
      exp_d[k]     = '0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].k == k) q.delete(i);
      return;
    end
    a = (k == 1) ? (int'(addr) % 4) : int'(addr);
    if (init_left[k] > 0) begin
      mm[k][D[k] - init_left[k]] = '0;
      init_left[k]--;
    end else begin
      if (en && wmode && a < D[k])
        for (int b = 0; b < W; b++)
          if (wmask[b / G[k]]) mm[k][a][b] = wdata[b];
      if (en && !wmode) begin
        r.k   = k;
        r.due = cyc_n + L[k] - 1;
        r.d   = (a < D[k]) ? mm[k][a] : '0;
        q.push_back(r);
      end
      if (init_req) init_left[k] = D[k];
    end
    exp_v[k] = 1'b0;
    idx = -1;
    for (int i = 0; i < q.size(); i++)
      if (q[i].k == k) begin
        idx = i;
        break;
      end
    if (idx >= 0 && q[idx].due == cyc_n) begin
      exp_v[k] = 1'b1;
      exp_d[k] = q[idx].d;
      q.delete(idx);
    end
  endfunction

  // Compare process: every cycle, all outputs of both instances.
  always @(posedge clk) begin
    cyc_n++;
    model_step(0);
    model_step(1);
    #1;
    chk1("a_ready",  ready_a,  init_left[0] == 0);
    chk1("b_ready",  ready_b,  init_left[1] == 0);
    chk1("a_rvalid", rvalid_a, exp_v[0]);
    chk1("b_rvalid", rvalid_b, exp_v[1]);
    chk ("a_rdata",  rdata_a,  exp_d[0]);
    chk ("b_rdata",  rdata_b,  exp_d[1]);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic e, input logic wm, input logic [2:0] a,
                     input logic [2:0] m, input logic [W-1:0] d);
    en = e; wmode = wm; addr = a; wmask = m; wdata = d;
  endtask

  task automatic idle();
    en = 1'b0; wmode = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
    return t[W-1:0];
  endfunction

  // Counts sampled not-ready cycles until both instances are ready (bounded).
  task automatic count_init(input int ea, input int eb, input string tag);
    int za = 0;
    int zb = 0;
    for (int n = 0; n < 30; n++) begin
      if (!ready_a) za++;
      if (!ready_b) zb++;
      if (ready_a && ready_b) break;
      cyc();
    end
    chk_int({tag, "_init_cycles_a"}, za, ea);
    chk_int({tag, "_init_cycles_b"}, zb, eb);
  endtask

  logic [W-1:0] ones, exp_ma, exp_mb;
  logic [W-1:0] vals [3];

  initial begin
    ones   = '1;
    exp_ma = '1; exp_ma[255:128] = '0;
    exp_mb = '1; exp_mb[199:100] = '0;
    rst_n = 1'b0; init_req = 1'b0;
    drv(1'b0, 1'b0, 3'd0, 3'd0, '0);
    repeat (3) cyc();
    chk1("rst_ready_a", ready_a, 1'b0);
    chk ("rst_rdata_a", rdata_a, '0);
    rst_n = 1'b1;
    count_init(5, 4, "boot");

    // Read every entry after boot
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b0, 3'(i), 3'd0, '0);
      cyc();
    end
    idle();
    repeat (3) cyc();

    // Segment mask
    drv(1'b1, 1'b1, 3'd2, 3'b111, ones);
    cyc();
    drv(1'b1, 1'b1, 3'd2, 3'b010, '0);
    cyc();
    drv(1'b1, 1'b0, 3'd2, 3'd0, '0);
    cyc();
    chk1("mask_rvalid_b", rvalid_b, 1'b1);
    chk ("mask_rdata_b",  rdata_b,  exp_mb);
    idle();
    cyc();
    chk1("mask_rvalid_a", rvalid_a, 1'b1);
    chk ("mask_rdata_a",  rdata_a,  exp_ma);
    cyc();

    // Back-to-back reads through the output register
    for (int i = 0; i < 3; i++) begin
      vals[i] = rand_w();
      drv(1'b1, 1'b1, 3'(i), 3'b111, vals[i]);
      cyc();
    end
    drv(1'b1, 1'b0, 3'd0, 3'd0, '0);
    cyc();
    drv(1'b1, 1'b0, 3'd1, 3'd0, '0);
    cyc();
    chk("b2b_a0", rdata_a, vals[0]);
    drv(1'b1, 1'b0, 3'd2, 3'd0, '0);
    cyc();
    chk("b2b_a1", rdata_a, vals[1]);
    idle();
    cyc();
    chk("b2b_a2", rdata_a, vals[2]);
    repeat (2) cyc();
    chk1("b2b_hold_rvalid_a", rvalid_a, 1'b0);
    chk ("b2b_hold_rdata_a",  rdata_a,  vals[2]);

    // Out-of-range address on the depth-5 instance
    drv(1'b1, 1'b1, 3'd6, 3'b111, ones);
    cyc();
    drv(1'b1, 1'b0, 3'd6, 3'd0, '0);
    cyc();
    idle();
    cyc();
    chk1("oor_rvalid_a", rvalid_a, 1'b1);
    chk ("oor_rdata_a",  rdata_a,  '0);
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b0, 3'(i), 3'd0, '0);
      cyc();
    end
    idle();
    repeat (3) cyc();

    // Re-initialisation, with a write attempted while it runs
    drv(1'b1, 1'b1, 3'd1, 3'b111, W'(5));
    cyc();
    idle();
    init_req = 1'b1;
    cyc();
    init_req = 1'b0;
    drv(1'b1, 1'b1, 3'd3, 3'b111, ones);
    cyc();
    idle();
    count_init(4, 3, "reinit");
    drv(1'b1, 1'b0, 3'd1, 3'd0, '0);
    cyc();
    chk1("reinit_rvalid_b", rvalid_b, 1'b1);
    chk ("reinit_rdata_b",  rdata_b,  '0);
    drv(1'b1, 1'b0, 3'd3, 3'd0, '0);
    cyc();
    chk ("reinit_rdata_a1", rdata_a, '0);
    chk ("reinit_rdata_b3", rdata_b, '0);
    idle();
    repeat (2) cyc();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      wmode    = $urandom_range(0, 1) == 1;
      addr     = 3'($urandom_range(0, 7));
      wmask    = 3'($urandom());
      wdata    = rand_w();
      init_req = ($urandom_range(0, 59) == 0);
      cyc();
    end
    init_req = 1'b0;
    idle();
    count_init(0, 0, "pre_rst");
    repeat (2) cyc();

    // Reset asserted two cycles into an init sequence
    drv(1'b1, 1'b1, 3'd3, 3'b111, ones);
    cyc();
    drv(1'b1, 1'b1, 3'd4, 3'b111, ones);
    cyc();
    drv(1'b1, 1'b0, 3'd3, 3'd0, '0);
    cyc();
    idle();
    repeat (2) cyc();
    init_req = 1'b1;
    cyc();
    init_req = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk1("midrst_rvalid_a", rvalid_a, 1'b0);
    chk ("midrst_rdata_a",  rdata_a,  '0);
    chk ("midrst_rdata_b",  rdata_b,  '0);
    chk1("midrst_ready_b",  ready_b,  1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    count_init(5, 4, "midrst");
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b0, 3'(i), 3'd0, '0);
      cyc();
    end
    idle();
    cyc();
    chk("midrst_rdata_a4", rdata_a, '0);
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
